state_snapshot_decoder: RTL and testbench

- Capture-and-decode block for the SAT bin engine's packed state buses: clause literal vector, variable-state list and level-state list.
- Latches a snapshot of each bus on its own strobe and presents decoded per-field values plus summary statistics.
- Sits beside the SAT engine as an observation/debug port; it never drives engine state.

---
 rtl/state_snapshot_decoder_pkg.sv | 37 +++
 rtl/state_snapshot_decoder_if.sv | 52 +++++
 rtl/state_snapshot_decoder_popcount_sat.sv | 20 ++
 rtl/state_snapshot_decoder.sv | 120 ++++++++++++
 tb/tb_state_snapshot_decoder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/state_snapshot_decoder_pkg.sv
// rtl/state_snapshot_decoder_pkg.sv - shared codes, field offsets and defaults for the snapshot decoder
package state_snapshot_decoder_pkg;

  localparam int DEF_NUM_VARS         = 8;
  localparam int DEF_NUM_LVLS         = 8;
  localparam int DEF_WIDTH_C_LEN      = 4;
  localparam int DEF_WIDTH_LVL        = 16;
  localparam int DEF_WIDTH_BIN_ID     = 10;
  localparam int DEF_WIDTH_VAR_STATES = 3 + DEF_WIDTH_LVL;
  localparam int DEF_WIDTH_LVL_STATES = DEF_WIDTH_BIN_ID + 1;

  typedef enum logic [1:0] {
    LIT_ABSENT = 2'b00,
    LIT_POS    = 2'b01,
    LIT_NEG    = 2'b10,
    LIT_INV    = 2'b11
  } lit_code_e;

  typedef enum logic [1:0] {
    VAL_UNASG = 2'b00,
    VAL_FALSE = 2'b01,
    VAL_TRUE  = 2'b10,
    VAL_INV   = 2'b11
  } val_code_e;

  localparam int VAR_VAL_LSB = 0;
  localparam int VAR_VAL_W   = 3;
  localparam int VAR_LVL_LSB = 3;
  localparam int LVL_BKT_BIT = 0;
  localparam int LVL_BIN_LSB = 1;

  // Invalid value code counts as unassigned, so only FALSE/TRUE qualify.
  function automatic logic val_assigned(logic [1:0] v);
    return (v == VAL_FALSE) || (v == VAL_TRUE);
  endfunction

endpackage

// File: rtl/state_snapshot_decoder_if.sv
// rtl/state_snapshot_decoder_if.sv - capture strobes, packed buses, selects and decoded outputs
interface state_snapshot_decoder_if
  import state_snapshot_decoder_pkg::*;
#(
  parameter int NUM_VARS         = DEF_NUM_VARS,
  parameter int NUM_LVLS         = DEF_NUM_LVLS,
  parameter int WIDTH_C_LEN      = DEF_WIDTH_C_LEN,
  parameter int WIDTH_LVL        = DEF_WIDTH_LVL,
  parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
  parameter int WIDTH_VAR_STATES = DEF_WIDTH_VAR_STATES,
  parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES,
  parameter int SEL_VAR_W        = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  parameter int SEL_LVL_W        = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1
);
  logic                                   clause_set_i;
  logic [NUM_VARS*2-1:0]                  clause_i;
  logic                                   vs_set_i;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_i;
  logic                                   ls_set_i;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   ls_i;
  logic [SEL_VAR_W-1:0]                   sel_var_i;
  logic [SEL_LVL_W-1:0]                   sel_lvl_i;

  logic                                   clause_valid_o;
  logic                                   vs_valid_o;
  logic                                   ls_valid_o;
  logic [NUM_VARS-1:0]                    lit_pos_o;
  logic [NUM_VARS-1:0]                    lit_neg_o;
  logic [WIDTH_C_LEN-1:0]                 clause_len_o;
  logic                                   clause_err_o;
  logic [2:0]                             var_value_o;
  logic [WIDTH_LVL-1:0]                   var_lvl_o;
  logic [WIDTH_C_LEN-1:0]                 num_assigned_o;
  logic [WIDTH_LVL-1:0]                   max_lvl_o;
  logic [WIDTH_BIN_ID-1:0]                lvl_bin_o;
  logic                                   lvl_has_bkt_o;
  logic [WIDTH_C_LEN-1:0]                 num_bkt_o;

  modport master (
    output clause_set_i, clause_i, vs_set_i, vs_i, ls_set_i, ls_i, sel_var_i, sel_lvl_i,
    input  clause_valid_o, vs_valid_o, ls_valid_o, lit_pos_o, lit_neg_o, clause_len_o,
           clause_err_o, var_value_o, var_lvl_o, num_assigned_o, max_lvl_o, lvl_bin_o,
           lvl_has_bkt_o, num_bkt_o
  );

  modport slave (
    input  clause_set_i, clause_i, vs_set_i, vs_i, ls_set_i, ls_i, sel_var_i, sel_lvl_i,
    output clause_valid_o, vs_valid_o, ls_valid_o, lit_pos_o, lit_neg_o, clause_len_o,
           clause_err_o, var_value_o, var_lvl_o, num_assigned_o, max_lvl_o, lvl_bin_o,
           lvl_has_bkt_o, num_bkt_o
  );
endinterface

// File: rtl/state_snapshot_decoder_popcount_sat.sv
// rtl/state_snapshot_decoder_popcount_sat.sv - popcount clamped at 2^W-1
module state_snapshot_decoder_popcount_sat #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [N-1:0] i_bits,
  output logic [W-1:0] o_count
);
  localparam int MAX_COUNT = (1 << W) - 1;

  int w_sum;

  always_comb begin
    w_sum = 0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + int'(i_bits[i]);
    end
    o_count = (w_sum > MAX_COUNT) ? W'(MAX_COUNT) : W'(w_sum);
  end
endmodule

// File: rtl/state_snapshot_decoder.sv
// rtl/state_snapshot_decoder.sv - latches SAT engine state buses on strobe and decodes fields/statistics
module state_snapshot_decoder
  import state_snapshot_decoder_pkg::*;
#(
  parameter int NUM_VARS         = DEF_NUM_VARS,
  parameter int NUM_LVLS         = DEF_NUM_LVLS,
  parameter int WIDTH_C_LEN      = DEF_WIDTH_C_LEN,
  parameter int WIDTH_LVL        = DEF_WIDTH_LVL,
  parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
  parameter int WIDTH_VAR_STATES = DEF_WIDTH_VAR_STATES,
  parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES
) (
  input logic                     clk,
  input logic                     rst,
  state_snapshot_decoder_if.slave bus
);
  localparam int SEL_VAR_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int SEL_LVL_W = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;

  logic [NUM_VARS*2-1:0]                r_clause;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] r_vs;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] r_ls;
  logic                                 r_clause_valid;
  logic                                 r_vs_valid;
  logic                                 r_ls_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clause       <= '0;
      r_vs           <= '0;
      r_ls           <= '0;
      r_clause_valid <= 1'b0;
      r_vs_valid     <= 1'b0;
      r_ls_valid     <= 1'b0;
    end else begin
      if (bus.clause_set_i) begin
        r_clause       <= bus.clause_i;
        r_clause_valid <= 1'b1;
      end
      if (bus.vs_set_i) begin
        r_vs       <= bus.vs_i;
        r_vs_valid <= 1'b1;
      end
      if (bus.ls_set_i) begin
        r_ls       <= bus.ls_i;
        r_ls_valid <= 1'b1;
      end
    end
  end

  logic [NUM_VARS-1:0]         w_lit_pos;
  logic [NUM_VARS-1:0]         w_lit_neg;
  logic [NUM_VARS-1:0]         w_lit_inv;
  logic [NUM_VARS-1:0]         w_var_asg;
  logic [WIDTH_LVL-1:0]        w_max_lvl;
  logic [WIDTH_VAR_STATES-1:0] w_var_sel;
  logic [NUM_LVLS-1:0]         w_lvl_bkt;
  logic [WIDTH_LVL_STATES-1:0] w_lvl_sel;

  always_comb begin
    w_lit_pos = '0;
    w_lit_neg = '0;
    w_lit_inv = '0;
    w_var_asg = '0;
    w_max_lvl = '0;
    w_var_sel = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      w_lit_pos[i] = (r_clause[2*i +: 2] == LIT_POS);
      w_lit_neg[i] = (r_clause[2*i +: 2] == LIT_NEG);
      w_lit_inv[i] = (r_clause[2*i +: 2] == LIT_INV);
      w_var_asg[i] = val_assigned(r_vs[i*WIDTH_VAR_STATES + VAR_VAL_LSB +: 2]);
      if (val_assigned(r_vs[i*WIDTH_VAR_STATES + VAR_VAL_LSB +: 2]) &&
          (r_vs[i*WIDTH_VAR_STATES + VAR_LVL_LSB +: WIDTH_LVL] > w_max_lvl)) begin
        w_max_lvl = r_vs[i*WIDTH_VAR_STATES + VAR_LVL_LSB +: WIDTH_LVL];
      end
      // No match leaves the select zero, which covers out-of-range indices.
      if (bus.sel_var_i == SEL_VAR_W'(i)) begin
        w_var_sel = r_vs[i*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
      end
    end
  end

  always_comb begin
    w_lvl_bkt = '0;
    w_lvl_sel = '0;
    for (int i = 0; i < NUM_LVLS; i++) begin
      w_lvl_bkt[i] = r_ls[i*WIDTH_LVL_STATES + LVL_BKT_BIT];
      if (bus.sel_lvl_i == SEL_LVL_W'(i)) begin
        w_lvl_sel = r_ls[i*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
      end
    end
  end

  state_snapshot_decoder_popcount_sat #(.N(NUM_VARS), .W(WIDTH_C_LEN)) u_clause_len (
    .i_bits  (w_lit_pos | w_lit_neg),
    .o_count (bus.clause_len_o)
  );

  state_snapshot_decoder_popcount_sat #(.N(NUM_VARS), .W(WIDTH_C_LEN)) u_num_assigned (
    .i_bits  (w_var_asg),
    .o_count (bus.num_assigned_o)
  );

  state_snapshot_decoder_popcount_sat #(.N(NUM_LVLS), .W(WIDTH_C_LEN)) u_num_bkt (
    .i_bits  (w_lvl_bkt),
    .o_count (bus.num_bkt_o)
  );

  assign bus.clause_valid_o = r_clause_valid;
  assign bus.vs_valid_o     = r_vs_valid;
  assign bus.ls_valid_o     = r_ls_valid;
  assign bus.lit_pos_o      = w_lit_pos;
  assign bus.lit_neg_o      = w_lit_neg;
  assign bus.clause_err_o   = |w_lit_inv;
  assign bus.var_value_o    = w_var_sel[VAR_VAL_LSB +: VAR_VAL_W];
  assign bus.var_lvl_o      = w_var_sel[VAR_LVL_LSB +: WIDTH_LVL];
  assign bus.max_lvl_o      = w_max_lvl;
  assign bus.lvl_bin_o      = w_lvl_sel[LVL_BIN_LSB +: WIDTH_BIN_ID];
  assign bus.lvl_has_bkt_o  = w_lvl_sel[LVL_BKT_BIT];
endmodule

// File: tb/tb_state_snapshot_decoder.sv
// tb/tb_state_snapshot_decoder.sv - directed-vector bench for state_snapshot_decoder
module tb_state_snapshot_decoder;
  localparam int NV = 8;
  localparam int NL = 8;
  localparam int VW = 19;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  state_snapshot_decoder_if bus ();

  state_snapshot_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [77:0] all_out();
    return {bus.clause_valid_o, bus.vs_valid_o, bus.ls_valid_o, bus.lit_pos_o, bus.lit_neg_o,
            bus.clause_len_o, bus.clause_err_o, bus.var_value_o, bus.var_lvl_o,
            bus.num_assigned_o, bus.max_lvl_o, bus.lvl_bin_o, bus.lvl_has_bkt_o, bus.num_bkt_o};
  endfunction

  task automatic test_reset();
    bus.clause_set_i = 1'b0; bus.vs_set_i = 1'b0; bus.ls_set_i = 1'b0;
    bus.clause_i = '0; bus.vs_i = '0; bus.ls_i = '0;
    bus.sel_var_i = '0; bus.sel_lvl_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (all_out() !== 78'd0) begin
      n_miss++; $display("FAIL reset_outputs: got %h want 0", all_out());
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clause();
    bus.clause_i = 16'h0019; bus.clause_set_i = 1'b1;
    @(negedge clk);
    bus.clause_set_i = 1'b0;
    n_vec++;
    if ({bus.clause_valid_o, bus.lit_pos_o, bus.lit_neg_o, bus.clause_len_o, bus.clause_err_o}
        !== {1'b1, 8'h05, 8'h02, 4'd3, 1'b0}) begin
      n_miss++; $display("FAIL clause_basic: got pos=%h neg=%h len=%0d err=%b", bus.lit_pos_o, bus.lit_neg_o, bus.clause_len_o, bus.clause_err_o);
    end
    bus.clause_i = 16'h00C0; bus.clause_set_i = 1'b1;
    @(negedge clk);
    bus.clause_set_i = 1'b0;
    n_vec++;
    if ({bus.lit_pos_o, bus.lit_neg_o, bus.clause_len_o, bus.clause_err_o} !== {8'h00, 8'h00, 4'd0, 1'b1}) begin
      n_miss++; $display("FAIL clause_invalid: got pos=%h neg=%h len=%0d err=%b want 0 0 0 1", bus.lit_pos_o, bus.lit_neg_o, bus.clause_len_o, bus.clause_err_o);
    end
    bus.clause_i = 16'h5557; bus.clause_set_i = 1'b1;
    @(negedge clk);
    bus.clause_set_i = 1'b0;
    n_vec++;
    if ({bus.lit_pos_o, bus.lit_neg_o, bus.clause_len_o, bus.clause_err_o} !== {8'hFE, 8'h00, 4'd7, 1'b1}) begin
      n_miss++; $display("FAIL clause_mixed: got pos=%h neg=%h len=%0d err=%b want fe 00 7 1", bus.lit_pos_o, bus.lit_neg_o, bus.clause_len_o, bus.clause_err_o);
    end
    bus.clause_i = 16'hAAAA; bus.clause_set_i = 1'b1;
    @(negedge clk);
    bus.clause_set_i = 1'b0;
    n_vec++;
    if ({bus.lit_neg_o, bus.clause_len_o, bus.clause_err_o} !== {8'hFF, 4'd8, 1'b0}) begin
      n_miss++; $display("FAIL clause_full_neg: got neg=%h len=%0d err=%b want ff 8 0", bus.lit_neg_o, bus.clause_len_o, bus.clause_err_o);
    end
  endtask

  task automatic test_var_states();
    logic [VW*NV-1:0] vs;
    vs = '0;
    vs[0*VW +: VW] = {16'd5, 3'b110};
    vs[2*VW +: VW] = {16'd9, 3'b001};
    vs[3*VW +: VW] = {16'd100, 3'b111};
    vs[5*VW +: VW] = {16'd50, 3'b100};
    bus.vs_i = vs; bus.vs_set_i = 1'b1; bus.sel_var_i = 3'd0;
    @(negedge clk);
    bus.vs_set_i = 1'b0;
    n_vec++;
    if ({bus.vs_valid_o, bus.var_value_o, bus.var_lvl_o} !== {1'b1, 3'b110, 16'd5}) begin
      n_miss++; $display("FAIL var_sel0: got val=%b lvl=%0d want 110 5", bus.var_value_o, bus.var_lvl_o);
    end
    n_vec++;
    if ({bus.num_assigned_o, bus.max_lvl_o} !== {4'd2, 16'd9}) begin
      n_miss++; $display("FAIL var_stats: got num=%0d max=%0d want 2 9", bus.num_assigned_o, bus.max_lvl_o);
    end
    bus.sel_var_i = 3'd2;
    #1;
    n_vec++;
    if ({bus.var_value_o, bus.var_lvl_o} !== {3'b001, 16'd9}) begin
      n_miss++; $display("FAIL var_sel2: got val=%b lvl=%0d want 001 9", bus.var_value_o, bus.var_lvl_o);
    end
    bus.sel_var_i = 3'd1;
    #1;
    n_vec++;
    if ({bus.var_value_o, bus.var_lvl_o} !== {3'b000, 16'd0}) begin
      n_miss++; $display("FAIL var_sel1: got val=%b lvl=%0d want 000 0", bus.var_value_o, bus.var_lvl_o);
    end
  endtask

  task automatic test_lvl_states();
    logic [LW*NL-1:0] ls;
    ls = '0;
    ls[1*LW +: LW] = {10'd37, 1'b1};
    ls[4*LW +: LW] = {10'd0, 1'b1};
    ls[7*LW +: LW] = {10'd1023, 1'b0};
    bus.ls_i = ls; bus.ls_set_i = 1'b1; bus.sel_lvl_i = 3'd1;
    @(negedge clk);
    bus.ls_set_i = 1'b0;
    n_vec++;
    if ({bus.ls_valid_o, bus.lvl_bin_o, bus.lvl_has_bkt_o, bus.num_bkt_o} !== {1'b1, 10'd37, 1'b1, 4'd2}) begin
      n_miss++; $display("FAIL lvl_sel1: got bin=%0d bkt=%b num=%0d want 37 1 2", bus.lvl_bin_o, bus.lvl_has_bkt_o, bus.num_bkt_o);
    end
    bus.sel_lvl_i = 3'd7;
    #1;
    n_vec++;
    if ({bus.lvl_bin_o, bus.lvl_has_bkt_o} !== {10'd1023, 1'b0}) begin
      n_miss++; $display("FAIL lvl_sel7: got bin=%0d bkt=%b want 1023 0", bus.lvl_bin_o, bus.lvl_has_bkt_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [VW*NV-1:0] vs;
    logic [LW*NL-1:0] ls;
    vs = '0;
    vs[7*VW +: VW] = {16'hFFFF, 3'b010};
    for (int i = 0; i < NL; i++) ls[i*LW +: LW] = {10'(i), 1'b1};
    bus.clause_i = 16'h0006; bus.vs_i = vs; bus.ls_i = ls;
    bus.sel_var_i = 3'd7; bus.sel_lvl_i = 3'd3;
    bus.clause_set_i = 1'b1; bus.vs_set_i = 1'b1; bus.ls_set_i = 1'b1;
    @(negedge clk);
    bus.clause_set_i = 1'b0; bus.vs_set_i = 1'b0; bus.ls_set_i = 1'b0;
    n_vec++;
    if ({bus.clause_valid_o, bus.vs_valid_o, bus.ls_valid_o, bus.lit_pos_o, bus.lit_neg_o, bus.clause_len_o}
        !== {3'b111, 8'h02, 8'h01, 4'd2}) begin
      n_miss++; $display("FAIL simul_clause: got pos=%h neg=%h len=%0d", bus.lit_pos_o, bus.lit_neg_o, bus.clause_len_o);
    end
    n_vec++;
    if ({bus.var_value_o, bus.var_lvl_o, bus.num_assigned_o, bus.max_lvl_o} !== {3'b010, 16'hFFFF, 4'd1, 16'hFFFF}) begin
      n_miss++; $display("FAIL simul_var: got val=%b lvl=%h num=%0d max=%h", bus.var_value_o, bus.var_lvl_o, bus.num_assigned_o, bus.max_lvl_o);
    end
    n_vec++;
    if ({bus.lvl_bin_o, bus.lvl_has_bkt_o, bus.num_bkt_o} !== {10'd3, 1'b1, 4'd8}) begin
      n_miss++; $display("FAIL simul_lvl: got bin=%0d bkt=%b num=%0d want 3 1 8", bus.lvl_bin_o, bus.lvl_has_bkt_o, bus.num_bkt_o);
    end
    bus.clause_i = 16'hFFFF; bus.vs_i = '0; bus.ls_i = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.lit_pos_o, bus.clause_err_o, bus.num_assigned_o, bus.num_bkt_o} !== {8'h02, 1'b0, 4'd1, 4'd8}) begin
      n_miss++; $display("FAIL hold_no_strobe: got pos=%h err=%b num=%0d bkt=%0d", bus.lit_pos_o, bus.clause_err_o, bus.num_assigned_o, bus.num_bkt_o);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    bus.clause_i = 16'h0019; bus.vs_i = '1; bus.ls_i = '1;
    bus.clause_set_i = 1'b1; bus.vs_set_i = 1'b1; bus.ls_set_i = 1'b1;
    #1;
    n_vec++;
    if (all_out() !== 78'd0) begin
      n_miss++; $display("FAIL async_reset: got %h want 0", all_out());
    end
    repeat (2) @(negedge clk);
    bus.clause_set_i = 1'b0; bus.vs_set_i = 1'b0; bus.ls_set_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (all_out() !== 78'd0) begin
      n_miss++; $display("FAIL strobe_during_reset: got %h want 0", all_out());
    end
    bus.clause_set_i = 1'b1;
    @(negedge clk);
    bus.clause_set_i = 1'b0;
    n_vec++;
    if ({bus.clause_valid_o, bus.vs_valid_o, bus.clause_len_o} !== {1'b1, 1'b0, 4'd3}) begin
      n_miss++; $display("FAIL capture_after_reset: got cv=%b vv=%b len=%0d want 1 0 3", bus.clause_valid_o, bus.vs_valid_o, bus.clause_len_o);
    end
  endtask

  initial begin
    test_reset();
    test_clause();
    test_var_states();
    test_lvl_states();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
